gb_clk_ctrl: RTL and testbench

- Parametrised successor of the single-bit halt toggle and fixed clock divider that gate the Game Boy core clock.
- Generates a one-cycle clock-enable tick for the core from one system clock.
- Supports RUN, HALT, STEP-N and TOGGLE commands, plus NUM_BP program-counter/read-address breakpoints that auto-halt the core.
- Sits between the UART debug command decoder and the core's clock-enable input. Status outputs feed the debug UART reporter.

---
 rtl/gb_dbg_pkg.sv | 40 ++++
 rtl/gb_bp_match.sv | 48 ++++
 rtl/gb_clk_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_gb_clk_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_dbg_pkg.sv
// ---------------------------------------------------------------------------
// gb_dbg_pkg
// Shared definitions for the Game Boy debug clock controller:
//   - cmd_op encodings (OP_NOP .. OP_CLRCNT)
//   - run-state enum (HALTED / RUNNING / STEPPING)
//   - breakpoint slot struct {en, addr}
//   - small integer helper used in port-width expressions
// Breakpoint addresses are stored zero-extended to BP_ADDR_W bits so the
// struct does not depend on the ADDR_W parameter of any one instance
// (ADDR_W must therefore be <= BP_ADDR_W).
// ---------------------------------------------------------------------------
package gb_dbg_pkg;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_RUN    = 3'd1;
   localparam logic [2:0] OP_HALT   = 3'd2;
   localparam logic [2:0] OP_STEP   = 3'd3;
   localparam logic [2:0] OP_SET_BP = 3'd4;
   localparam logic [2:0] OP_CLR_BP = 3'd5;
   localparam logic [2:0] OP_TOGGLE = 3'd6;
   localparam logic [2:0] OP_CLRCNT = 3'd7;

   typedef enum logic [1:0] {
      ST_HALTED   = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_STEPPING = 2'd2
   } gb_state_e;

   localparam int BP_ADDR_W = 32;

   typedef struct packed {
      logic                 en;
      logic [BP_ADDR_W-1:0] addr;
   } bp_slot_t;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gb_bp_match.sv
// ---------------------------------------------------------------------------
// gb_bp_match
// Combinational breakpoint comparator bank with lowest-index priority.
// Ports:
//   slots    in   NUM_BP breakpoint slots {en, addr}
//   bus_addr in   core address bus
//   bus_rd   in   core read strobe
//   any_hit  out  at least one enabled slot matches a read of bus_addr
//   hit_idx  out  lowest matching slot index (0 when nothing matches)
// The caller qualifies any_hit with its own tick enable.
// ---------------------------------------------------------------------------
module gb_bp_match
   import gb_dbg_pkg::*;
#(
   parameter int  NUM_BP = 2,
   parameter int  ADDR_W = 16,
   localparam int SEL_W  = max_i(1, $clog2(NUM_BP))
)(
   input  bp_slot_t [NUM_BP-1:0] slots,
   input  logic [ADDR_W-1:0]     bus_addr,
   input  logic                  bus_rd,
   output logic                  any_hit,
   output logic [SEL_W-1:0]      hit_idx
);

   logic [BP_ADDR_W-1:0] addr_ext;
   logic [NUM_BP-1:0]    match;

   assign addr_ext = BP_ADDR_W'(bus_addr);

   genvar gi;
   for (gi = 0; gi < NUM_BP; gi++) begin : g_cmp
      assign match[gi] = slots[gi].en & bus_rd & (slots[gi].addr == addr_ext);
   end

   assign any_hit = |match;

   // Scan from the top down so the lowest matching slot is written last.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/gb_clk_ctrl.sv
// ---------------------------------------------------------------------------
// gb_clk_ctrl
// Debug clock-enable generator for the Game Boy core. Produces a one-cycle
// gb_ce tick every 2*DIV_2N clk cycles while not halted, and implements the
// RUN / HALT / STEP / TOGGLE debug commands plus NUM_BP read-address
// breakpoints that auto-halt the core.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cmd_valid    command strobe
//   cmd_ready    command accepted when cmd_valid & cmd_ready (low on tick)
//   cmd_op       command opcode (see gb_dbg_pkg OP_*)
//   cmd_arg      step count (STEP) or breakpoint address (SET_BP)
//   cmd_sel      breakpoint slot for SET_BP / CLR_BP
//   bus_addr     core address bus
//   bus_rd       core read strobe
//   gb_ce        one-cycle core tick
//   halted       high while HALTED
//   bp_hit       one-cycle pulse after a breakpoint fires
//   bp_idx       slot that last fired (held until the next hit)
//   tick_cnt     gb_ce pulse counter (only with GB_CLK_CTRL_CYCLE_CNT_EN)
//   steps_left   remaining STEP ticks
//
// Build option: define GB_CLK_CTRL_CYCLE_CNT_EN to add tick_cnt; op 7
// then clears it, otherwise op 7 is a NOP.
// ---------------------------------------------------------------------------
module gb_clk_ctrl
   import gb_dbg_pkg::*;
#(
   parameter int  DIV_2N       = 6,
   parameter int  STEP_W       = 16,
   parameter int  NUM_BP       = 2,
   parameter int  ADDR_W       = 16,
   parameter int  START_HALTED = 0,
   localparam int ARG_W        = max_i(STEP_W, ADDR_W),
   localparam int SEL_W        = max_i(1, $clog2(NUM_BP))
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ARG_W-1:0]  cmd_arg,
   input  logic [SEL_W-1:0]  cmd_sel,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_rd,
   output logic              gb_ce,
   output logic              halted,
   output logic              bp_hit,
   output logic [SEL_W-1:0]  bp_idx,
`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
   output logic [31:0]       tick_cnt,
`endif
   output logic [STEP_W-1:0] steps_left
);

   localparam int DIV_LAST = 2 * DIV_2N - 1;
   localparam int DIV_W    = max_i(1, $clog2(2 * DIV_2N));
   localparam gb_state_e RESET_STATE = (START_HALTED != 0) ? ST_HALTED : ST_RUNNING;

   // ------------------------------------------------------------------
   // Free-running divider: never stalls, so halting and resuming keeps
   // the core tick on the same phase.
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt_reg;
   logic             tick_slot;

   assign tick_slot = (div_cnt_reg == DIV_W'(DIV_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
      end else if (tick_slot) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
   end

   // Commands are refused on tick cycles, so a command and a tick never
   // compete for the same state update.
   logic cmd_accept;
   assign cmd_ready  = ~tick_slot;
   assign cmd_accept = cmd_valid & ~tick_slot;

   // ------------------------------------------------------------------
   // Breakpoint slots
   // ------------------------------------------------------------------
   bp_slot_t [NUM_BP-1:0] slots;

   genvar gi;
   for (gi = 0; gi < NUM_BP; gi++) begin : g_slot
      bp_slot_t slot_reg;
      logic     sel_this;

      // A cmd_sel beyond the last slot matches no slot and is dropped.
      assign sel_this = cmd_accept & (cmd_sel == SEL_W'(gi));

      always_ff @(posedge clk) begin
         if (rst) begin
            slot_reg <= '0;
         end else if (sel_this) begin
            if (cmd_op == OP_SET_BP) begin
               slot_reg.en   <= 1'b1;
               slot_reg.addr <= BP_ADDR_W'(cmd_arg[ADDR_W-1:0]);
            end else if (cmd_op == OP_CLR_BP) begin
               slot_reg.en <= 1'b0;
            end
         end
      end

      assign slots[gi] = slot_reg;
   end

   logic             any_hit;
   logic [SEL_W-1:0] hit_idx;

   gb_bp_match #(
      .NUM_BP (NUM_BP),
      .ADDR_W (ADDR_W)
   ) u_bp_match (
      .slots    (slots),
      .bus_addr (bus_addr),
      .bus_rd   (bus_rd),
      .any_hit  (any_hit),
      .hit_idx  (hit_idx)
   );

   // ------------------------------------------------------------------
   // Run-state FSM
   // ------------------------------------------------------------------
   gb_state_e         state_reg,  state_next;
   logic [STEP_W-1:0] steps_reg,  steps_next;
   logic              bp_hit_reg, bp_hit_next;
   logic [SEL_W-1:0]  bp_idx_reg, bp_idx_next;
   logic [STEP_W-1:0] step_n;

   assign step_n = cmd_arg[STEP_W-1:0];
   assign gb_ce  = tick_slot & (state_reg != ST_HALTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= RESET_STATE;
         steps_reg  <= '0;
         bp_hit_reg <= 1'b0;
         bp_idx_reg <= '0;
      end else begin
         state_reg  <= state_next;
         steps_reg  <= steps_next;
         bp_hit_reg <= bp_hit_next;
         bp_idx_reg <= bp_idx_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      steps_next  = steps_reg;
      bp_hit_next = 1'b0;
      bp_idx_next = bp_idx_reg;

      if (gb_ce) begin
         // The ticked access completes; the halt lands on the next edge.
         // A breakpoint takes priority over the step count running out.
         if (any_hit) begin
            state_next  = ST_HALTED;
            steps_next  = '0;
            bp_hit_next = 1'b1;
            bp_idx_next = hit_idx;
         end else if (state_reg == ST_STEPPING) begin
            steps_next = steps_reg - STEP_W'(1);
            if (steps_reg == STEP_W'(1)) begin
               state_next = ST_HALTED;
            end
         end
      end else if (cmd_accept) begin
         case (cmd_op)
            OP_RUN: begin
               state_next = ST_RUNNING;
               steps_next = '0;
            end
            OP_HALT: begin
               state_next = ST_HALTED;
               steps_next = '0;
            end
            OP_TOGGLE: begin
               state_next = (state_reg == ST_HALTED) ? ST_RUNNING : ST_HALTED;
            end
            OP_STEP: begin
               if (step_n != '0) begin
                  state_next = ST_STEPPING;
                  steps_next = step_n;
               end
            end
            default: ;
         endcase
      end
   end

   assign halted     = (state_reg == ST_HALTED);
   assign bp_hit     = bp_hit_reg;
   assign bp_idx     = bp_idx_reg;
   assign steps_left = steps_reg;

`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
   logic [31:0] tick_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_reg <= '0;
      end else if (gb_ce) begin
         tick_cnt_reg <= tick_cnt_reg + 32'd1;
      end else if (cmd_accept && (cmd_op == OP_CLRCNT)) begin
         tick_cnt_reg <= '0;
      end
   end

   assign tick_cnt = tick_cnt_reg;
`endif

endmodule

// File: tb/tb_gb_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_clk_ctrl
// Directed bench for gb_clk_ctrl (DIV_2N=6, NUM_BP=2, START_HALTED=0).
// The stimulus thread pushes the expected gb_ce / bp_hit events (cycle,
// steps_left, slot) into a queue; a monitor pops one entry every time the
// DUT raises gb_ce or bp_hit and compares. cyc counts clk edges since the
// last reset release, so the k-th tick lands at cyc 11 + 12*k.
// ---------------------------------------------------------------------------
module tb_gb_clk_ctrl;
   import gb_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic [0:0]  cmd_sel;
   logic [15:0] bus_addr;
   logic        bus_rd;
   logic        gb_ce;
   logic        halted;
   logic        bp_hit;
   logic [0:0]  bp_idx;
   logic [15:0] steps_left;
`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
   logic [31:0] tick_cnt;
`endif

   gb_clk_ctrl #(
      .DIV_2N       (6),
      .STEP_W       (16),
      .NUM_BP       (2),
      .ADDR_W       (16),
      .START_HALTED (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_arg    (cmd_arg),
      .cmd_sel    (cmd_sel),
      .bus_addr   (bus_addr),
      .bus_rd     (bus_rd),
      .gb_ce      (gb_ce),
      .halted     (halted),
      .bp_hit     (bp_hit),
      .bp_idx     (bp_idx),
`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
      .tick_cnt   (tick_cnt),
`endif
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      int kind;   // 0 = gb_ce tick, 1 = bp_hit pulse
      int cyc;
      int steps;
      int idx;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic push_tick(input int c, input int s);
      ev_t e;
      e.kind = 0; e.cyc = c; e.steps = s; e.idx = 0;
      exp_q.push_back(e);
   endtask

   task automatic push_bp(input int c, input int i);
      ev_t e;
      e.kind = 1; e.cyc = c; e.steps = 0; e.idx = i;
      exp_q.push_back(e);
   endtask

   // Monitor: one queue entry per observed gb_ce or bp_hit.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            if (gb_ce === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_gb_ce: got gb_ce=1 expected none at cyc %0d", cyc);
               end else begin
                  e = exp_q.pop_front();
                  $display("tick   cyc=%0d steps_left=%0d (exp cyc=%0d steps=%0d)",
                           cyc, steps_left, e.cyc, e.steps);
                  chk("tick_kind", 0, e.kind);
                  chk("tick_cyc", cyc, e.cyc);
                  chk("tick_steps_left", int'(steps_left), e.steps);
                  chk("tick_halted", int'(halted), 0);
               end
            end
            if (bp_hit === 1'b1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_bp_hit: got bp_hit=1 idx=%0d expected none at cyc %0d",
                           bp_idx, cyc);
               end else begin
                  e = exp_q.pop_front();
                  $display("bp_hit cyc=%0d bp_idx=%0d (exp cyc=%0d idx=%0d)",
                           cyc, bp_idx, e.cyc, e.idx);
                  chk("bp_kind", 1, e.kind);
                  chk("bp_cyc", cyc, e.cyc);
                  chk("bp_idx", int'(bp_idx), e.idx);
                  chk("bp_halted", int'(halted), 1);
                  chk("bp_steps_left", int'(steps_left), 0);
               end
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [15:0] arg, input logic [0:0] sel);
      bit acc = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_sel = sel;
      for (int t = 0; t < 16 && !acc; t++) begin
         acc = (cmd_ready === 1'b1);
         @(negedge clk);
      end
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0; cmd_sel = '0;
      $display("cmd    op=%0d arg=0x%0h sel=%0d done at cyc %0d", op, arg, sel, cyc);
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL cmd_timeout: got no acceptance expected cmd_ready within 16 cycles (op %0d)", op);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0; cmd_sel = '0;
      bus_addr = '0; bus_rd = 1'b0;
      repeat (3) @(negedge clk);
      // Reset values
      chk("rst_halted", int'(halted), 0);
      chk("rst_steps_left", int'(steps_left), 0);
      chk("rst_bp_hit", int'(bp_hit), 0);
      chk("rst_bp_idx", int'(bp_idx), 0);
      chk("rst_gb_ce", int'(gb_ce), 0);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      rst = 1'b0;

      // Free running: ticks at 11, 23, 35
      push_tick(11, 0); push_tick(23, 0); push_tick(35, 0);
      wait_cyc(36);
      chk("run_halted", int'(halted), 0);

      // HALT, then STEP 3
      send(OP_HALT, 16'h0, 1'b0);                 // accepted -> cyc 37
      chk("halt_halted", int'(halted), 1);
      wait_cyc(50);
      push_tick(59, 3); push_tick(71, 2); push_tick(83, 1);
      send(OP_STEP, 16'd3, 1'b0);                 // -> cyc 51
      chk("step_loaded", int'(steps_left), 3);
      chk("step_halted", int'(halted), 0);
      wait_cyc(60);
      chk("step_after1", int'(steps_left), 2);
      wait_cyc(84);
      chk("step_done_halted", int'(halted), 1);
      chk("step_done_steps", int'(steps_left), 0);
      wait_cyc(96);

      // Breakpoint slot 1 at 0x0150 while RUNNING
      send(OP_SET_BP, 16'h0150, 1'b1);            // -> 97
      push_tick(107, 0); push_bp(108, 1);
      send(OP_RUN, 16'h0, 1'b0);                  // -> 98
      bus_addr = 16'h0150; bus_rd = 1'b1;
      wait_cyc(108);
      chk("bp1_halted", int'(halted), 1);
      chk("bp1_idx", int'(bp_idx), 1);
      wait_cyc(125);
      bus_rd = 1'b0;

      // Both slots on 0x0100 during STEP 1: lowest slot wins
      send(OP_SET_BP, 16'h0100, 1'b0);            // -> 126
      send(OP_SET_BP, 16'h0100, 1'b1);            // -> 127
      bus_addr = 16'h0100; bus_rd = 1'b1;
      push_tick(131, 1); push_bp(132, 0);
      send(OP_STEP, 16'd1, 1'b0);                 // -> 128
      chk("step1_loaded", int'(steps_left), 1);
      wait_cyc(132);
      chk("bp0_halted", int'(halted), 1);
      chk("bp0_steps", int'(steps_left), 0);
      chk("bp0_idx", int'(bp_idx), 0);
      wait_cyc(142);
      bus_rd = 1'b0;

      // Command presented on a tick cycle is taken one cycle later
      wait_cyc(143);
      chk("tick_cmd_ready", int'(cmd_ready), 0);
      cmd_valid = 1'b1; cmd_op = OP_RUN;
      @(negedge clk);                              // cyc 144
      chk("tick_cmd_not_taken", int'(halted), 1);
      chk("post_tick_cmd_ready", int'(cmd_ready), 1);
      @(negedge clk);                              // cyc 145
      cmd_valid = 1'b0; cmd_op = OP_NOP;
      chk("tick_cmd_taken", int'(halted), 0);
      push_tick(155, 0);
      wait_cyc(156);
      send(OP_TOGGLE, 16'h0, 1'b0);               // -> 157
      chk("toggle_to_halt", int'(halted), 1);
      send(OP_TOGGLE, 16'h0, 1'b0);               // -> 158
      chk("toggle_to_run", int'(halted), 0);
      push_tick(167, 0);
      wait_cyc(168);

      // Reset in the middle of a STEP
      push_tick(179, 5);
      send(OP_STEP, 16'd5, 1'b0);                 // -> 169
      wait_cyc(180);
      chk("step5_after1", int'(steps_left), 4);
      wait_cyc(185);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst_halted", int'(halted), 0);
      chk("midrst_steps", int'(steps_left), 0);
      rst = 1'b0;

      // Slots must be cleared: reads of the old address must not halt
      bus_addr = 16'h0100; bus_rd = 1'b1;
      for (int k = 0; k < 100; k++) push_tick(11 + 12 * k, 0);
      wait_cyc(1200);
      chk("post_rst_running", int'(halted), 0);
`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
      chk("tick_cnt_100", int'(tick_cnt), 100);
`endif
      send(OP_CLRCNT, 16'h0, 1'b0);               // -> 1201
`ifdef GB_CLK_CTRL_CYCLE_CNT_EN
      chk("tick_cnt_clr", int'(tick_cnt), 0);
`endif
      chk("op7_halted", int'(halted), 0);
      chk("op7_steps", int'(steps_left), 0);
      bus_rd = 1'b0;
      wait_cyc(1205);
      chk("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
